prom_loader: RTL
================

Name: prom_loader

Overview:
- Program-ROM responder on the cpu instruction-fetch interface: takes prom_addr from the cpu and returns a 32-bit instruction with one-cycle registered latency.
- Also owns a byte-serial loader that fills the program memory from a host stream (valid/ready) while the cpu is held off.
- Sits beside cpu at the top level; cpu_run gates the fetch side.

Parameters:
- DEPTH_LOG2, 10, log2 of program memory depth in 32-bit words (1024 words).
- ADDR_W, 16, width of prom_addr.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- prom_addr  in  ADDR_W  instruction word address from cpu
- instruction  out  32  fetched instruction word, registered
- cpu_run  out  1  high only in RUN; cpu holds/ignores fetch when low
- load_start  in  1  single-cycle pulse: begin (re)load
- load_end  in  1  single-cycle pulse: stream finished
- load_valid  in  1  load_data valid
- load_data  in  8  program byte
- load_ready  out  1  byte accepted when load_valid && load_ready
- word_count  out  DEPTH_LOG2+1  words written by last load
- load_err  out  1  sticky overflow/checksum error, cleared by load_start
- load_sum  out  8  running byte checksum (0 when feature is out)

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: instruction=0, cpu_run=0, load_ready=0, word_count=0, load_err=0, load_sum=0.
  - Internal: state=IDLE, byte counter and pointer cleared.
  - Memory array is not reset; contents are undefined after power-up.
- States and transitions:
  - IDLE -> LOAD on load_start.
  - LOAD -> FLUSH on load_end when 1-3 bytes of a word are pending.
  - LOAD -> RUN on load_end when no bytes are pending.
  - FLUSH -> RUN after one cycle.
  - RUN -> LOAD on load_start.
- load_start:
  - Honoured in any state, including mid-LOAD (restart).
  - Effects: clear write pointer, byte counter, word_count, load_err and load_sum; cpu_run drops the next cycle.
  - Same-cycle load_start and load_end: load_start wins.
- LOAD byte assembly:
  - load_ready=1 unless memory is full.
  - Bytes are little-endian: the first byte of a word goes to bits 7:0 (opcode byte), the 4th to bits 31:24.
  - On the 4th byte, the word is written to mem[wptr] in the same clock edge; wptr and word_count increment.
- FLUSH:
  - Missing high bytes of the partial word are zero-padded.
  - The word is written to mem[wptr]; word_count increments.
- Full memory:
  - When wptr==2^DEPTH_LOG2, load_ready=0.
  - A byte offered with load_valid=1 sets load_err=1 and is dropped.
  - The state stays LOAD until load_end, then proceeds normally.
- Fetch:
  - In RUN, instruction <= mem[prom_addr[DEPTH_LOG2-1:0]] if the address is below word_count and prom_addr upper bits are zero; otherwise instruction <= 32'h0 (NOP).
  - Latency is exactly 1 clock; a new address is accepted every cycle.
  - Outside RUN, instruction <= 0.
- Loader writes and fetch reads are never simultaneous (state-exclusive); the memory needs a single port only.
- load_end in IDLE or RUN is ignored.
- Reset mid-LOAD: everything returns to reset values; partially loaded memory is left as-is but unreachable because word_count=0.

Optional Feature:
- Macro PROM_CHECKSUM_EN.
- With the macro:
  - load_sum accumulates (mod 256) every accepted byte, including the host's trailing checksum byte.
  - The checksum byte is treated as data.
  - On exit from LOAD/FLUSH, if load_sum!=0: set load_err=1 and go to IDLE instead of RUN.
- Without the macro:
  - load_sum is tied to 0; no check is made.
  - load_err is set only by overflow.

Decomposition:
- Package prom_pkg holds:
  - state enum {IDLE, LOAD, FLUSH, RUN}
  - INST_W=32
  - BYTES_PER_WORD=4
  - NOP_INST=32'h0
- One sub-module, prom_mem: single-port synchronous RAM, DEPTH_LOG2 address bits, 32-bit data, write enable, registered read. The loader FSM and fetch gating live in prom_loader.

Test Plan:
- Reset, then prom_addr=0 for 5 cycles -> instruction=0, cpu_run=0, load_ready=0 throughout.
- load_start; bytes 01 02 03 04 05 06 07 08; load_end -> word_count=2 and cpu_run=1. Then prom_addr=0,1,2 back-to-back -> instruction=0x04030201, 0x08070605, 0x00000000, each 1 cycle after its address.
- Load 6 bytes AA BB CC DD 11 22; load_end -> FLUSH; word_count=2; mem[1]=0x00002211.
- DEPTH_LOG2=2: stream 17 bytes -> load_ready=0 after the 16th byte; load_err=1 when the 17th byte is offered; load_end -> RUN with word_count=4.
- load_start mid-LOAD after 3 bytes, then 4 new bytes and load_end -> word_count=1; mem[0] holds only the new bytes. Also assert rst_n mid-LOAD -> all outputs return to reset values immediately.
- With PROM_CHECKSUM_EN:
  - bytes 10 20 30 A0 -> sum=0, RUN.
  - bytes 10 20 30 A1 -> load_err=1, state IDLE, cpu_run=0.

Source files
------------

// File: rtl/prom_pkg.sv
// Shared types and constants for the program-ROM loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package prom_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} state_e;

   localparam int              INST_W         = 32;
   localparam int              BYTES_PER_WORD = 4;
   localparam logic [INST_W-1:0] NOP_INST     = 32'h0;
endpackage

// File: rtl/prom_mem.sv
// Single-port program RAM: synchronous write, registered read.
// Latency: read data valid 1 clock after the address; write lands on the same edge.
// Backpressure: none; a write cycle suppresses the read update for that cycle.
module prom_mem
   import prom_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [DEPTH_LOG2-1:0] addr_i,
   input  logic [INST_W-1:0]     wdata_i,
   output logic [INST_W-1:0]     rdata_o
);
   // Contents are deliberately not reset; power-up values are undefined.
   logic [INST_W-1:0] mem_q [2**DEPTH_LOG2];
   logic [INST_W-1:0] rdata_q;

   // One access per cycle: either write the word or register the read.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end else begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/prom_loader.sv
// Program ROM: byte-serial host loader into RAM plus 1-cycle instruction fetch for the cpu.
// Latency: instruction valid 1 clock after prom_addr; a loaded word is written on its 4th byte.
// Backpressure: load_ready drops when memory is full. Optional checksum check: PROM_CHECKSUM_EN.
module prom_loader
   import prom_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10,
   parameter int ADDR_W     = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_W-1:0]     prom_addr,
   output logic [INST_W-1:0]     instruction,
   output logic                  cpu_run,
   input  logic                  load_start,
   input  logic                  load_end,
   input  logic                  load_valid,
   input  logic [7:0]            load_data,
   output logic                  load_ready,
   output logic [DEPTH_LOG2:0]   word_count,
   output logic                  load_err,
   output logic [7:0]            load_sum
);
   localparam int              CW   = DEPTH_LOG2 + 1;
   localparam int              BW   = $clog2(BYTES_PER_WORD);
   localparam logic [CW-1:0]   FULL = CW'(2**DEPTH_LOG2);

   state_e           state_q, state_d;
   logic [CW-1:0]    wcnt_q, wcnt_d;     // write pointer, doubles as word count
   logic [BW-1:0]    bcnt_q, bcnt_d;     // bytes pending in the partial word
   logic [23:0]      buf_q, buf_d;       // low three bytes of the partial word
   logic             err_q, err_d;
   logic [7:0]       sum_q, sum_d;
   logic             hit_q, hit_d;

   logic                  full;
   logic                  addr_ok;
   logic                  mem_we;
   logic [DEPTH_LOG2-1:0] mem_addr;
   logic [INST_W-1:0]     mem_wdata;
   logic [INST_W-1:0]     mem_rdata;

   assign full    = (wcnt_q == FULL);
   assign addr_ok = (prom_addr[ADDR_W-1:DEPTH_LOG2] == '0) &&
                    ({1'b0, prom_addr[DEPTH_LOG2-1:0]} < wcnt_q);
   // Loader and fetch never share a cycle, so one port is steered by state.
   assign mem_addr = (state_q == RUN) ? prom_addr[DEPTH_LOG2-1:0] : wcnt_q[DEPTH_LOG2-1:0];

   // Next-state, byte assembly and memory write control.
   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      bcnt_d    = bcnt_q;
      buf_d     = buf_q;
      err_d     = err_q;
      sum_d     = sum_q;
      mem_we    = 1'b0;
      mem_wdata = {8'h00, buf_q};
      hit_d     = (state_q == RUN) && addr_ok;

      if (load_start) begin
         // Restart wins over everything, including a same-cycle load_end.
         state_d = LOAD;
         wcnt_d  = '0;
         bcnt_d  = '0;
         buf_d   = '0;
         err_d   = 1'b0;
         sum_d   = '0;
      end else begin
         case (state_q)
            LOAD: begin
               if (load_valid) begin
                  if (full) begin
                     err_d = 1'b1;  // overflow byte is dropped
                  end else begin
`ifdef PROM_CHECKSUM_EN
                     sum_d = sum_q + load_data;
`endif
                     if (bcnt_q == BW'(BYTES_PER_WORD - 1)) begin
                        mem_we    = 1'b1;
                        mem_wdata = {load_data, buf_q};
                        wcnt_d    = wcnt_q + CW'(1);
                        bcnt_d    = '0;
                        buf_d     = '0;
                     end else begin
                        buf_d[{bcnt_q, 3'b000} +: 8] = load_data;
                        bcnt_d = bcnt_q + BW'(1);
                     end
                  end
               end
               if (load_end) begin
                  if (bcnt_d != '0) begin
                     state_d = FLUSH;
                  end else begin
                     state_d = RUN;
`ifdef PROM_CHECKSUM_EN
                     if (sum_d != 8'h00) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                     end
`endif
                  end
               end
            end
            FLUSH: begin
               // Untouched high byte lanes are already zero in buf_q.
               mem_we  = 1'b1;
               wcnt_d  = wcnt_q + CW'(1);
               bcnt_d  = '0;
               buf_d   = '0;
               state_d = RUN;
`ifdef PROM_CHECKSUM_EN
               if (sum_q != 8'h00) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end
`endif
            end
            default: ;  // IDLE and RUN ignore load_end
         endcase
      end
   end

   // State and loader registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         wcnt_q  <= '0;
         bcnt_q  <= '0;
         buf_q   <= '0;
         err_q   <= 1'b0;
         sum_q   <= '0;
         hit_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         bcnt_q  <= bcnt_d;
         buf_q   <= buf_d;
         err_q   <= err_d;
         sum_q   <= sum_d;
         hit_q   <= hit_d;
      end
   end

   prom_mem #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
      .clk     (clk),
      .we_i    (mem_we),
      .addr_i  (mem_addr),
      .wdata_i (mem_wdata),
      .rdata_o (mem_rdata)
   );

   // hit_q masks the undefined RAM output outside RUN or for unloaded addresses.
   assign instruction = hit_q ? mem_rdata : NOP_INST;
   assign cpu_run     = (state_q == RUN);
   assign load_ready  = (state_q == LOAD) && !full;
   assign word_count  = wcnt_q;
   assign load_err    = err_q;
   assign load_sum    = sum_q;
endmodule
